// File: rtl/psum_accumulator.sv
// psum_accumulator: realigns PE-array issue flags with psum_out, accumulates K tiles
// per output vector, requantizes to int8 and queues results behind a credit scheme.
// Optional build macro PSUM_ROUND_EN: round-half-up before the requant shift.

module psum_accumulator #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int ACC_DEPTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(ACC_DEPTH):0]      cfg_num_vec,
    input  logic [4:0]                      cfg_shift,
    input  logic                            cfg_relu,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic                            in_last,
    output logic                            in_ready,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  psum_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ARRAY_DIM*OUT_WIDTH-1:0]  out_data,
    output logic                            busy,
    output logic                            err_overflow
);
    localparam int AW = $clog2(ACC_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int VW = ARRAY_DIM * ACC_WIDTH;
    localparam int QW = ARRAY_DIM * OUT_WIDTH;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    // ---------------- issue-flag realignment ----------------
    logic [ARRAY_DIM-1:0] dl_valid_q, dl_first_q, dl_last_q;
    logic                 d_valid, d_first, d_last;

    assign d_valid = dl_valid_q[ARRAY_DIM-1];
    assign d_first = dl_first_q[ARRAY_DIM-1];
    assign d_last  = dl_last_q[ARRAY_DIM-1];

    // ---------------- accumulator buffer ----------------
    logic [AW-1:0] acc_addr_q, acc_addr_d;
    logic [AW:0]   last_addr;
    logic [VW-1:0] acc_mem [ACC_DEPTH];
    logic [VW-1:0] acc_rd;
    logic [VW-1:0] col_sum;
    logic [VW-1:0] sum_q;
    logic          rq_valid_q;
    logic [QW-1:0] rq_data;

    assign last_addr = cfg_num_vec - 1'b1;
    assign acc_rd    = acc_mem[acc_addr_q];

    always_comb begin
        acc_addr_d = acc_addr_q;
        if (d_valid) begin
            if ({1'b0, acc_addr_q} == last_addr) begin
                acc_addr_d = '0;
            end else begin
                acc_addr_d = acc_addr_q + 1'b1;
            end
        end
    end

    // First K tile overwrites; later tiles add modulo 2^ACC_WIDTH.
    generate
        for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_sum
            assign col_sum[gi*ACC_WIDTH +: ACC_WIDTH] = d_first
                ? psum_in[gi*ACC_WIDTH +: ACC_WIDTH]
                : acc_rd[gi*ACC_WIDTH +: ACC_WIDTH] + psum_in[gi*ACC_WIDTH +: ACC_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (d_valid) begin
            acc_mem[acc_addr_q] <= col_sum;
        end
        if (d_valid && d_last) begin
            sum_q <= col_sum;
        end
    end

    // ---------------- requantization ----------------
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic [ACC_WIDTH-1:0] x,
        input logic [4:0]           sh,
        input logic                 relu
    );
        logic signed [ACC_WIDTH:0] v;
        logic [OUT_WIDTH-1:0]      r;
`ifdef PSUM_ROUND_EN
        logic [ACC_WIDTH:0]        rnd;
`endif
        v = $signed({x[ACC_WIDTH-1], x});
`ifdef PSUM_ROUND_EN
        // One extra bit of headroom keeps the rounding add from wrapping.
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1);
        end
        v = v + $signed(rnd);
`endif
        v = v >>> sh;
        if (relu && v[ACC_WIDTH]) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_rq
            assign rq_data[gi*OUT_WIDTH +: OUT_WIDTH] =
                requant(sum_q[gi*ACC_WIDTH +: ACC_WIDTH], cfg_shift, cfg_relu);
        end
    endgenerate

    // ---------------- output FIFO (show-ahead) ----------------
    logic [QW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // A result arriving at a full FIFO is only possible after a credit violation; drop it.
    assign fifo_push  = rq_valid_q && !fifo_full;
    assign fifo_pop   = !fifo_empty && out_ready;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= rq_data;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PW-1:0]];

    // ---------------- credits and error flag ----------------
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;
    logic          take;

    assign take     = in_valid && in_last;
    assign in_ready = (credit_q != '0);

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({take, fifo_pop})
            2'b10: begin
                if (credit_q != '0) begin
                    credit_d = credit_q - 1'b1;
                end
            end
            2'b01: begin
                if (credit_q != CREDIT_MAX) begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
        if (take && !in_ready) begin
            err_d = 1'b1;
        end
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid_q <= '0;
            dl_first_q <= '0;
            dl_last_q  <= '0;
            acc_addr_q <= '0;
            rq_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            credit_q   <= CREDIT_MAX;
            err_q      <= 1'b0;
        end else begin
            dl_valid_q <= {dl_valid_q[ARRAY_DIM-2:0], in_valid};
            dl_first_q <= {dl_first_q[ARRAY_DIM-2:0], in_first};
            dl_last_q  <= {dl_last_q[ARRAY_DIM-2:0], in_last};
            acc_addr_q <= acc_addr_d;
            rq_valid_q <= d_valid && d_last;
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign err_overflow = err_q;
    assign busy         = (|dl_valid_q) || rq_valid_q || !fifo_empty;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed latency/requant/credit/reset steps plus randomized
// K-tile passes, checked against a vector-level reference model of the accumulator.

module tb_psum_accumulator;
    localparam int DIM = 16;
    localparam int AW  = 32;
    localparam int OW  = 8;
    localparam int VW  = DIM * AW;
    localparam int QW  = DIM * OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    cfg_num_vec;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic          in_valid, in_first, in_last, in_ready;
    logic [VW-1:0] psum_in;
    logic          out_valid, out_ready;
    logic [QW-1:0] out_data;
    logic          busy, err_overflow;

    psum_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_num_vec  (cfg_num_vec),
        .cfg_shift    (cfg_shift),
        .cfg_relu     (cfg_relu),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .psum_in      (psum_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: per-address accumulated vectors, expected output queue, credits.
    logic [VW-1:0] m_buf [16];
    int            m_addr, m_num, m_credit, m_shift;
    bit            m_err, m_relu;
    logic [QW-1:0] exp_q [$];
    logic [VW-1:0] sched [32];
    bit            sched_v [32];

    task automatic chk(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_requant(input logic [31:0] x, input int sh, input bit relu);
        longint v;
        v = longint'($signed(x));
`ifdef PSUM_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic logic [VW-1:0] splat(input logic [31:0] x);
        logic [VW-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*AW +: AW] = x;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int c = 0; c < DIM; c++) begin
            if ($urandom_range(0, 3) == 0) v[c*AW +: AW] = $urandom;
            else v[c*AW +: AW] = 32'($urandom_range(0, 4000)) - 32'd2000;
        end
        return v;
    endfunction

    function automatic logic [QW-1:0] expect_vec(input logic [VW-1:0] acc);
        logic [QW-1:0] e;
        for (int c = 0; c < DIM; c++) e[c*OW +: OW] = ref_requant(acc[c*AW +: AW], m_shift, m_relu);
        return e;
    endfunction

    task automatic step();
        bit            pop, take;
        logic [QW-1:0] e;
        pop  = out_valid && out_ready;
        take = in_valid && in_last;
        if (pop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL pop_unexpected: observed=%h expected=no output", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
            end
        end
        if (take && m_credit == 0) m_err = 1'b1;
        m_credit = m_credit - (take ? 1 : 0) + (pop ? 1 : 0);
        if (m_credit < 0) m_credit = 0;
        if (m_credit > 4) m_credit = 4;
        @(posedge clk);
        #1;
        cycle++;
        if (sched_v[cycle % 32]) begin
            psum_in = sched[cycle % 32];
            sched_v[cycle % 32] = 1'b0;
        end else begin
            psum_in = rand_vec();
        end
        chk("in_ready", QW'(in_ready), QW'(m_credit != 0));
        chk("err_overflow", QW'(err_overflow), QW'(m_err));
    endtask

    task automatic issue(input bit first, input bit last, input logic [VW-1:0] p);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        sched[(cycle + 16) % 32]   = p;
        sched_v[(cycle + 16) % 32] = 1'b1;
        if (first) begin
            m_buf[m_addr] = p;
        end else begin
            for (int c = 0; c < DIM; c++) m_buf[m_addr][c*AW +: AW] = m_buf[m_addr][c*AW +: AW] + p[c*AW +: AW];
        end
        // A violating issue in this bench always meets a full FIFO, so its result is lost.
        if (last && m_credit != 0) exp_q.push_back(expect_vec(m_buf[m_addr]));
        m_addr = (m_addr + 1) % m_num;
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic set_cfg(input int num, input int sh, input bit relu);
        cfg_num_vec = 5'(num);
        cfg_shift   = 5'(sh);
        cfg_relu    = relu;
        m_num   = num;
        m_shift = sh;
        m_relu  = relu;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 300 && busy; n++) step();
        chk("drain_idle", QW'(busy), '0);
        chk("drain_left", QW'(exp_q.size()), '0);
        out_ready = 1'b0;
    endtask

    task automatic wait_out_valid();
        for (int n = 0; n < 40 && !out_valid; n++) step();
        chk("out_valid_wait", QW'(out_valid), QW'(1));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_credit = 4;
        m_err    = 1'b0;
        m_addr   = 0;
        for (int i = 0; i < 32; i++) sched_v[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, QW'(in_ready), QW'(1));
        chk({tag, "_out_valid"}, QW'(out_valid), '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_busy"}, QW'(busy), '0);
        chk({tag, "_err"}, QW'(err_overflow), '0);
    endtask

    task automatic t3(input logic [31:0] p, input int sh, input bit relu, input logic [7:0] e8, input string tag);
        set_cfg(1, sh, relu);
        issue(1'b1, 1'b1, splat(p));
        wait_out_valid();
        chk(tag, QW'(out_data[7:0]), QW'(e8));
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            c0, nk, num;
        logic [VW-1:0] p;
        logic [QW-1:0] v60;

        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; psum_in = '0;
        set_cfg(1, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // T1: latency 18 cycles from issue to out_valid
        set_cfg(1, 0, 0);
        c0 = cycle;
        p = '0;
        p[31:0] = 32'd5;
        issue(1'b1, 1'b1, p);
        chk("t1_busy", QW'(busy), QW'(1));
        while (cycle < c0 + 17) step();
        chk("t1_early", QW'(out_valid), '0);
        step();
        chk("t1_valid", QW'(out_valid), QW'(1));
        chk("t1_col0", QW'(out_data[7:0]), QW'(8'd5));
        drain();

        // T2: two vectors, three K tiles of 10/20/30
        set_cfg(2, 0, 0);
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 2; v++) issue(k == 0, k == 2, splat(32'(10 * (k + 1))));
        wait_out_valid();
        for (int c = 0; c < DIM; c++) v60[c*OW +: OW] = 8'd60;
        chk("t2_sum60", out_data, v60);
        drain();

        // T3: requant saturation, relu and shift/rounding
        t3(-32'sd300, 1, 1'b0, 8'h80, "t3_sat");
        t3(-32'sd300, 1, 1'b1, 8'h00, "t3_relu");
`ifdef PSUM_ROUND_EN
        t3(32'd7, 1, 1'b0, 8'd4, "t3_shift");
`else
        t3(32'd7, 1, 1'b0, 8'd3, "t3_shift");
`endif

        // T4/T5: credits exhausted, then a violating fifth issue
        set_cfg(1, 0, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, rand_vec());
        chk("t4_no_credit", QW'(in_ready), '0);
        chk("t4_no_err", QW'(err_overflow), '0);
        issue(1'b1, 1'b1, rand_vec());
        chk("t5_err_set", QW'(err_overflow), QW'(1));
        repeat (25) step();
        chk("t5_full_valid", QW'(out_valid), QW'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_credit_back", QW'(in_ready), QW'(1));
        drain();
        chk("t5_err_sticky", QW'(err_overflow), QW'(1));

        // T6: reset mid-pass, then a fresh pass
        set_cfg(4, 2, 1'b0);
        for (int v = 0; v < 4; v++) issue(1'b1, 1'b0, rand_vec());
        for (int v = 0; v < 2; v++) issue(1'b0, 1'b1, rand_vec());
        repeat (15) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        cycle += 2;
        model_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 4; v++) issue(k == 0, k == 1, rand_vec());
        drain();

        // Randomized passes with random backpressure
        for (int pass = 0; pass < 8; pass++) begin
            num = int'($urandom_range(1, 16));
            nk  = int'($urandom_range(1, 3));
            set_cfg(num, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < nk; k++) begin
                for (int v = 0; v < num; v++) begin
                    if (k == nk - 1) begin
                        for (int n = 0; n < 100 && !in_ready; n++) begin
                            out_ready = 1'b1;
                            step();
                        end
                        chk("rand_in_ready_wait", QW'(in_ready), QW'(1));
                    end
                    out_ready = 1'($urandom_range(0, 1));
                    issue(k == 0, k == nk - 1, rand_vec());
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                        out_ready = 1'($urandom_range(0, 1));
                        step();
                    end
                end
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
